// File: rtl/pwm_multi.sv
// N-channel PWM generator: shared prescaled period counter (edge- or centre-aligned),
// double-buffered duty/period applied only at period boundaries, registered outputs.
module pwm_multi #(
  parameter int unsigned N      = 32'd3,
  parameter int unsigned W      = 32'd8,
  parameter int unsigned PW     = 32'd8,
  parameter bit          CENTER = 1'b0,
  parameter bit          INVERT = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [PW-1:0]  prescale,
  input  logic [W-1:0]   period,
  input  logic [N*W-1:0] duty,
  input  logic           load,
  output logic [N-1:0]   pwm_o,
  output logic           period_end_o,
  output logic           pending_o
);

  logic [PW-1:0]  presc_cnt_r;
  logic [W-1:0]   counter_r;
  logic           dir_down_r;
  logic [W-1:0]   shadow_period_r;
  logic [W-1:0]   act_period_r;
  logic [N*W-1:0] shadow_duty_r;
  logic [N*W-1:0] act_duty_r;
  logic           pending_r;
  logic           period_end_r;
  logic [N-1:0]   pwm_r;

  logic           tick_s;
  logic           wrap_s;
  logic           boundary_s;
  logic [PW-1:0]  presc_next_s;
  logic [W-1:0]   step_cnt_s;
  logic           step_down_s;
  logic [W-1:0]   new_period_s;
  logic [W-1:0]   counter_next_s;
  logic           dir_next_s;
  logic           pending_next_s;
  logic [N-1:0]   pwm_next_s;

  assign tick_s = en && (presc_cnt_r == prescale);

  // Prescaler advance and counter stepping / wrap detection for the selected count mode
  always_comb begin
    presc_next_s = presc_cnt_r;
    wrap_s       = 1'b0;
    step_cnt_s   = counter_r;
    step_down_s  = dir_down_r;
    if (en) begin
      if (tick_s) begin
        presc_next_s = '0;
      end else begin
        presc_next_s = presc_cnt_r + PW'(1'b1);
      end
    end else begin
      presc_next_s = presc_cnt_r;
    end
    if (CENTER == 1'b0) begin
      if (counter_r == act_period_r) begin
        wrap_s = 1'b1;
      end else begin
        step_cnt_s = counter_r + W'(1'b1);
      end
    end else begin
      // A zero period never leaves 0, so every tick is a boundary
      if ((act_period_r == '0) || (dir_down_r && (counter_r == '0))) begin
        wrap_s = 1'b1;
      end else if (!dir_down_r && (counter_r == act_period_r)) begin
        step_down_s = 1'b1;
        step_cnt_s  = counter_r - W'(1'b1);
      end else if (dir_down_r) begin
        step_cnt_s = counter_r - W'(1'b1);
      end else begin
        step_cnt_s = counter_r + W'(1'b1);
      end
    end
  end

  assign boundary_s   = tick_s && wrap_s;
  assign new_period_s = pending_r ? shadow_period_r : act_period_r;

  // Next counter/direction/pending state; restart value uses the period taking effect now
  always_comb begin
    counter_next_s = counter_r;
    dir_next_s     = dir_down_r;
    pending_next_s = pending_r;
    if (boundary_s) begin
      dir_next_s = 1'b0;
      if ((CENTER == 1'b1) && (new_period_s != '0)) begin
        counter_next_s = W'(1'b1);
      end else begin
        counter_next_s = '0;
      end
    end else if (tick_s) begin
      counter_next_s = step_cnt_s;
      dir_next_s     = step_down_s;
    end else begin
      counter_next_s = counter_r;
      dir_next_s     = dir_down_r;
    end
    if (load) begin
      pending_next_s = 1'b1;
    end else if (boundary_s) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Per-channel compare against the current counter and active duty
  always_comb begin
    pwm_next_s = '0;
    for (int i = 0; i < int'(N); i++) begin
      pwm_next_s[i] = ((counter_r < act_duty_r[i*W +: W]) & en) ^ INVERT;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_r     <= '0;
      counter_r       <= '0;
      dir_down_r      <= 1'b0;
      shadow_period_r <= '0;
      act_period_r    <= '0;
      shadow_duty_r   <= '0;
      act_duty_r      <= '0;
      pending_r       <= 1'b0;
      period_end_r    <= 1'b0;
      pwm_r           <= {N{INVERT}};
    end else begin
      presc_cnt_r  <= presc_next_s;
      counter_r    <= counter_next_s;
      dir_down_r   <= dir_next_s;
      pending_r    <= pending_next_s;
      period_end_r <= boundary_s;
      pwm_r        <= pwm_next_s;
      // Active takes the shadow as it was before this cycle's load, if any
      if (boundary_s && pending_r) begin
        act_period_r <= shadow_period_r;
        act_duty_r   <= shadow_duty_r;
      end
      if (load) begin
        shadow_period_r <= period;
        shadow_duty_r   <= duty;
      end
    end
  end

  assign pwm_o        = pwm_r;
  assign period_end_o = period_end_r;
  assign pending_o    = pending_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: three instances (edge, centre, edge+inverted) on shared stimulus,
// a per-cycle scoreboard against a behavioural model, plus table-driven period measurements.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [7:0]  prescale, period;
  logic [23:0] duty;
  logic [2:0]  pwm_w [3];
  logic        pe_w  [3];
  logic        pend_w[3];

  always #5 clk = ~clk;

  pwm_multi #(.N(3), .W(8), .PW(8), .CENTER(1'b0), .INVERT(1'b0)) u_edge (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .period(period), .duty(duty),
    .load(load), .pwm_o(pwm_w[0]), .period_end_o(pe_w[0]), .pending_o(pend_w[0]));
  pwm_multi #(.N(3), .W(8), .PW(8), .CENTER(1'b1), .INVERT(1'b0)) u_ctr (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .period(period), .duty(duty),
    .load(load), .pwm_o(pwm_w[1]), .period_end_o(pe_w[1]), .pending_o(pend_w[1]));
  pwm_multi #(.N(3), .W(8), .PW(8), .CENTER(1'b0), .INVERT(1'b1)) u_inv (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .period(period), .duty(duty),
    .load(load), .pwm_o(pwm_w[2]), .period_end_o(pe_w[2]), .pending_o(pend_w[2]));

  typedef struct packed {
    logic [7:0]      presc;
    logic [7:0]      cnt;
    logic            down;
    logic [7:0]      sh_p;
    logic [2:0][7:0] sh_d;
    logic [7:0]      act_p;
    logic [2:0][7:0] act_d;
    logic            pend;
    logic            pe;
    logic [2:0]      pwm;
  } mdl_t;

  typedef struct packed {
    logic [1:0] k;
    logic [2:0] pwm;
    logic       pe;
    logic       pend;
  } exp_t;

  typedef struct {
    logic [7:0] ps, per, d0, d1, d2;
    int len_e, hi_e0, hi_e1, hi_e2;
    int len_c, hi_c0, hi_c1, hi_c2;
  } vec_t;

  mdl_t  m[3];
  exp_t  sb_q[$];
  vec_t  vecs[4];
  int    errors = 0;
  int    checks = 0;
  int    meas_len;
  int    meas_hi[3];

  function automatic mdl_t mstep(mdl_t s, bit center, bit invert, bit rst_i, bit en_i,
                                 logic [7:0] ps, logic [7:0] per, logic [23:0] du, bit ld);
    mdl_t n;
    bit   tick, bnd;
    n = s;
    if (rst_i) begin
      n = '0;
      n.pwm = {3{invert}};
      return n;
    end
    for (int i = 0; i < 3; i++) n.pwm[i] = ((s.cnt < s.act_d[i]) && en_i) ^ invert;
    tick = en_i && (s.presc == ps);
    if (en_i) n.presc = tick ? 8'd0 : s.presc + 8'd1;
    bnd = 1'b0;
    if (tick) begin
      if (!center) begin
        if (s.cnt == s.act_p) bnd = 1'b1;
        else n.cnt = s.cnt + 8'd1;
      end else if (s.act_p == 8'd0 || (s.down && s.cnt == 8'd0)) begin
        bnd = 1'b1;
      end else if (!s.down && s.cnt == s.act_p) begin
        n.down = 1'b1;
        n.cnt  = s.cnt - 8'd1;
      end else begin
        n.cnt = s.down ? s.cnt - 8'd1 : s.cnt + 8'd1;
      end
    end
    if (bnd) begin
      if (s.pend) begin
        n.act_p = s.sh_p;
        n.act_d = s.sh_d;
        n.pend  = 1'b0;
      end
      n.down = 1'b0;
      n.cnt  = (center && n.act_p != 8'd0) ? 8'd1 : 8'd0;
    end
    n.pe = bnd;
    if (ld) begin
      n.sh_p = per;
      n.sh_d = du;
      n.pend = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // One clock: model predictions go into the scoreboard, then are compared after the edge
  task automatic cyc();
    for (int k = 0; k < 3; k++) begin
      m[k] = mstep(m[k], k == 1, k == 2, rst, en, prescale, period, duty, load);
      sb_q.push_back({2'(k), m[k].pwm, m[k].pe, m[k].pend});
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk($sformatf("sb_pwm[%0d]", e.k), 32'(pwm_w[e.k]), 32'(e.pwm));
      chk($sformatf("sb_pe[%0d]", e.k), 32'(pe_w[e.k]), 32'(e.pe));
      chk($sformatf("sb_pend[%0d]", e.k), 32'(pend_w[e.k]), 32'(e.pend));
    end
  endtask

  task automatic wait_pe(input int k);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!pe_w[k] && n < 1200);
    chk($sformatf("wait_pe[%0d]", k), 32'(pe_w[k]), 32'd1);
  endtask

  // Counts cycles and active-level samples up to and including the next period_end pulse
  task automatic count_period(input int k);
    meas_len = 0;
    meas_hi  = '{0, 0, 0};
    do begin
      cyc();
      meas_len++;
      for (int i = 0; i < 3; i++) meas_hi[i] += (pwm_w[k][i] ^ (k == 2)) ? 1 : 0;
    end while (!pe_w[k] && meas_len < 1200);
  endtask

  initial begin
    vecs[0] = '{8'd0, 8'd9,   8'd3,   8'd0,   8'd10, 10,  3,   0,   10, 18,  5,   0,   18};
    vecs[1] = '{8'd1, 8'd4,   8'd2,   8'd5,   8'd1,  10,  4,   10,  2,  16,  6,   16,  2};
    vecs[2] = '{8'd2, 8'd0,   8'd0,   8'd1,   8'd2,  3,   0,   3,   3,  3,   0,   3,   3};
    vecs[3] = '{8'd0, 8'd255, 8'd255, 8'd128, 8'd1,  256, 255, 128, 1,  510, 509, 255, 1};

    rst = 1'b1; en = 1'b0; load = 1'b0;
    prescale = 8'd0; period = 8'd0; duty = 24'd0;
    cyc();
    cyc();
    chk("rst_pwm_edge", 32'(pwm_w[0]), 32'd0);
    chk("rst_pwm_inv", 32'(pwm_w[2]), 32'd7);
    chk("rst_pend", 32'(pend_w[0]), 32'd0);
    rst = 1'b0; en = 1'b1;

    for (int v = 0; v < 4; v++) begin
      prescale = vecs[v].ps;
      period   = vecs[v].per;
      duty     = {vecs[v].d2, vecs[v].d1, vecs[v].d0};
      load     = 1'b1;
      cyc();
      load = 1'b0;
      for (int k = 0; k < 3; k++) begin
        wait_pe(k);
        count_period(k);
        chk($sformatf("v%0d_len[%0d]", v, k), 32'(meas_len), 32'(k == 1 ? vecs[v].len_c : vecs[v].len_e));
        chk($sformatf("v%0d_hi0[%0d]", v, k), 32'(meas_hi[0]), 32'(k == 1 ? vecs[v].hi_c0 : vecs[v].hi_e0));
        chk($sformatf("v%0d_hi1[%0d]", v, k), 32'(meas_hi[1]), 32'(k == 1 ? vecs[v].hi_c1 : vecs[v].hi_e1));
        chk($sformatf("v%0d_hi2[%0d]", v, k), 32'(meas_hi[2]), 32'(k == 1 ? vecs[v].hi_c2 : vecs[v].hi_e2));
      end
    end

    // Duty change mid-period: current period keeps 3, next uses 7
    prescale = 8'd0; period = 8'd9; duty = {8'd10, 8'd0, 8'd3};
    load = 1'b1; cyc(); load = 1'b0;
    wait_pe(0);
    wait_pe(0);
    meas_hi[0] = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      meas_hi[0] += pwm_w[0][0] ? 1 : 0;
    end
    duty = {8'd10, 8'd0, 8'd7};
    load = 1'b1; cyc(); load = 1'b0;
    meas_hi[0] += pwm_w[0][0] ? 1 : 0;
    chk("mid_pend_set", 32'(pend_w[0]), 32'd1);
    for (int i = 0; i < 20 && !pe_w[0]; i++) begin
      cyc();
      meas_hi[0] += pwm_w[0][0] ? 1 : 0;
    end
    chk("mid_old_duty", 32'(meas_hi[0]), 32'd3);
    chk("mid_pend_clr", 32'(pend_w[0]), 32'd0);
    count_period(0);
    chk("mid_new_duty", 32'(meas_hi[0]), 32'd7);

    // Load A then load B landing on the boundary cycle
    for (int i = 0; i < 8; i++) cyc();
    duty = {8'd10, 8'd0, 8'd4};
    load = 1'b1; cyc();
    duty = {8'd10, 8'd0, 8'd6};
    cyc(); load = 1'b0;
    chk("coinc_boundary", 32'(pe_w[0]), 32'd1);
    chk("coinc_pend", 32'(pend_w[0]), 32'd1);
    count_period(0);
    chk("coinc_a_duty", 32'(meas_hi[0]), 32'd4);
    chk("coinc_pend_clr", 32'(pend_w[0]), 32'd0);
    count_period(0);
    chk("coinc_b_duty", 32'(meas_hi[0]), 32'd6);

    // en low for 5 cycles mid-period stretches the period to 15 cycles
    meas_len = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      meas_len++;
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      meas_len++;
      chk("en0_pwm_inv", 32'(pwm_w[2]), 32'd7);
      chk("en0_pwm_edge", 32'(pwm_w[0]), 32'd0);
      chk("en0_pe", 32'(pe_w[0]), 32'd0);
    end
    en = 1'b1;
    for (int i = 0; i < 40 && !pe_w[0]; i++) begin
      cyc();
      meas_len++;
    end
    chk("en0_period_len", 32'(meas_len), 32'd15);

    // Reset while a load is pending mid-period
    for (int i = 0; i < 4; i++) cyc();
    period = 8'd5; duty = {8'd1, 8'd2, 8'd3};
    load = 1'b1; cyc(); load = 1'b0;
    cyc(); cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst2_pwm_edge", 32'(pwm_w[0]), 32'd0);
    chk("rst2_pwm_inv", 32'(pwm_w[2]), 32'd7);
    chk("rst2_pend", 32'(pend_w[0]), 32'd0);
    chk("rst2_pe", 32'(pe_w[0]), 32'd0);
    cyc();
    chk("rst2_restart_pe", 32'(pe_w[0]), 32'd1);
    for (int i = 0; i < 10; i++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
